// File: rtl/bf_useq_pkg.sv
// bf_pkg: shared opcode, next-mode, microword field and state definitions for the BF sequencer.
package bf_pkg;
   typedef enum logic [2:0] {
      OP_RIGHT, OP_LEFT, OP_INC, OP_DEC, OP_OUT, OP_IN, OP_JBEG, OP_JEND
   } op_e;
   localparam logic [1:0] NM_SEQ = 2'b00;
   localparam logic [1:0] NM_END = 2'b01;
   localparam logic [1:0] NM_BZ  = 2'b10;
   localparam logic [1:0] NM_JMP = 2'b11;
   localparam int MW_NM_HI  = 15;
   localparam int MW_NM_LO  = 14;
   localparam int MW_TGT_HI = 13;
   localparam int MW_TGT_LO = 8;
   localparam int MW_CTL_HI = 7;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_e;
endpackage

// File: rtl/bf_useq_if.sv
// bf_useq_if: opcode handshake, microcode store and datapath control signals of the sequencer.
interface bf_useq_if #(parameter int UPC_W = 6);
   logic             op_valid;
   logic [2:0]       op;
   logic             op_ready;
   logic [UPC_W-1:0] upc;
   logic [15:0]      uword;
   logic             zero;
   logic [7:0]       ctrl;
   logic             ctrl_valid;
   logic             ctrl_stall;
   modport master (output op_valid, op, uword, zero, ctrl_stall,
                   input op_ready, upc, ctrl, ctrl_valid);
   modport slave  (input op_valid, op, uword, zero, ctrl_stall,
                   output op_ready, upc, ctrl, ctrl_valid);
endinterface

// File: rtl/bf_useq_next.sv
// bf_useq_next: next micro-PC selection with end-of-op and overflow detection.
module bf_useq_next import bf_pkg::*; #(
   parameter int UPC_W = 6
) (
   input  logic [1:0]       mode,
   input  logic [UPC_W-1:0] target,
   input  logic [UPC_W-1:0] upc,
   input  logic             zero,
   output logic [UPC_W-1:0] next_upc,
   output logic             done,
   output logic             ovf
);
   logic jump;
   assign jump     = (mode == NM_JMP) || (mode == NM_BZ && zero);
   assign done     = mode == NM_END;
   assign next_upc = jump ? target : upc + UPC_W'(1);
   // sequential advance past the last store word must not wrap
   assign ovf      = !done && !jump && (upc == '1);
endmodule

// File: rtl/bf_useq.sv
// bf_useq: microcode sequencer dispatching BF opcodes through a 2**UPC_W x 16 microcode store.
module bf_useq import bf_pkg::*; #(
   parameter int UPC_W     = 6,
   parameter int OP_STRIDE = 8,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   bf_useq_if.slave         bus,
   output logic             busy,
   output logic             uerr,
   output logic [CNT_W-1:0] ucount
);
   state_e           state, state_n;
   logic [UPC_W-1:0] upc_q, upc_n, nxt;
   logic [CNT_W-1:0] ucount_n;
   logic [7:0]       ctrl_q;
   logic             busy_n, uerr_n, done, ovf, exec;

   bf_useq_next #(.UPC_W(UPC_W)) u_next (
      .mode    (bus.uword[MW_NM_HI:MW_NM_LO]),
      .target  (UPC_W'(bus.uword[MW_TGT_HI:MW_TGT_LO])),
      .upc     (upc_q),
      .zero    (bus.zero),
      .next_upc(nxt),
      .done    (done),
      .ovf     (ovf)
   );

   assign exec           = state == S_EXEC;
   assign bus.op_ready   = (state == S_IDLE) && rst_n;
   assign bus.ctrl_valid = exec;
   assign bus.ctrl       = exec ? bus.uword[MW_CTL_HI:0] : ctrl_q;
   assign bus.upc        = upc_q;

   always_comb begin
      state_n  = state;
      upc_n    = upc_q;
      busy_n   = busy;
      uerr_n   = uerr;
      ucount_n = ucount;
      unique case (state)
         S_IDLE: if (bus.op_valid) begin
            upc_n   = UPC_W'(bus.op) * UPC_W'(OP_STRIDE);
            busy_n  = 1'b1;
            state_n = S_FETCH;
         end
         S_FETCH: state_n = S_EXEC;
         S_EXEC: if (!bus.ctrl_stall) begin
            ucount_n = ucount + CNT_W'(ucount != '1);
            if (done || ovf) begin
               busy_n  = 1'b0;
               uerr_n  = uerr | ovf;
               state_n = S_IDLE;
            end else begin
               upc_n   = nxt;
               state_n = S_FETCH;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         upc_q  <= '0;
         ctrl_q <= '0;
         busy   <= 1'b0;
         uerr   <= 1'b0;
         ucount <= '0;
      end else begin
         state  <= state_n;
         upc_q  <= upc_n;
         ctrl_q <= bus.ctrl;
         busy   <= busy_n;
         uerr   <= uerr_n;
         ucount <= ucount_n;
      end
   end
endmodule

// File: tb/tb_bf_useq.sv
// tb_bf_useq: directed scoreboard bench for the BF microcode sequencer.
module tb_bf_useq;
   import bf_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bf_useq_if #(.UPC_W(6)) bus ();
   bf_useq_if #(.UPC_W(6)) sbus ();
   logic        busy, uerr, sbusy, suerr;
   logic [15:0] ucount;
   logic [3:0]  sucount;
   logic [15:0] mem [64];
   logic [7:0]  exp_q [$];
   int vecs = 0;
   int errs = 0;
   int n;

   bf_useq dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .uerr(uerr), .ucount(ucount));
   bf_useq #(.CNT_W(4)) u_sat (.clk(clk), .rst_n(rst_n), .bus(sbus), .busy(sbusy), .uerr(suerr), .ucount(sucount));

   always_ff @(posedge clk) begin
      bus.uword  <= mem[bus.upc];
      sbus.uword <= mem[sbus.upc];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk)
      if (rst_n && bus.ctrl_valid && !bus.ctrl_stall) begin
         if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL ctrl_unexpected: got %0h expected none", bus.ctrl);
         end else chk("ctrl", {24'h0, bus.ctrl}, {24'h0, exp_q.pop_front()});
      end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [2:0] o);
      int t = 0;
      while (!bus.op_ready && t < 50) begin
         step();
         t++;
      end
      chk("op_ready", bus.op_ready, 1);
      bus.op_valid = 1'b1;
      bus.op = o;
      step();
      bus.op_valid = 1'b0;
      bus.op = 3'($urandom);
   endtask

   task automatic wait_idle(output int c);
      c = 0;
      while (busy && c < 200) begin
         step();
         c++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.op_valid = 0; bus.op = 0; bus.zero = 0; bus.ctrl_stall = 0;
      sbus.op_valid = 0; sbus.op = 0; sbus.zero = 0; sbus.ctrl_stall = 0;
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      mem[8] = 16'h4011;
      repeat (2) step();
      chk("rst_ctrl_valid", bus.ctrl_valid, 0);
      chk("rst_upc", bus.upc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_uerr", uerr, 0);
      chk("rst_ucount", ucount, 0);
      chk("rst_op_ready", bus.op_ready, 0);
      chk("rst_ctrl", bus.ctrl, 0);
      // single END word at op 1 (base 8)
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("op_ready_release", bus.op_ready, 1);
      exp_q.push_back(8'h11);
      bus.op_valid = 1'b1;
      bus.op = OP_LEFT;
      step();
      bus.op_valid = 1'b0;
      chk("t1_upc", bus.upc, 8);
      chk("t1_busy", busy, 1);
      chk("t1_fetch_ready", bus.op_ready, 0);
      chk("t1_fetch_valid", bus.ctrl_valid, 0);
      step();
      chk("t1_exec_valid", bus.ctrl_valid, 1);
      chk("t1_exec_ctrl", bus.ctrl, 8'h11);
      step();
      chk("t1_done_ready", bus.op_ready, 1);
      chk("t1_done_busy", busy, 0);
      chk("t1_ucount", ucount, 1);
      chk("t1_ctrl_hold", bus.ctrl, 8'h11);
      chk("t1_valid_low", bus.ctrl_valid, 0);
      // branch on zero, taken and not taken
      mem[48] = 16'h8F05; mem[15] = 16'h40AA; mem[49] = 16'h4033;
      bus.zero = 1'b1;
      exp_q.push_back(8'h05); exp_q.push_back(8'hAA);
      start_op(OP_JBEG);
      wait_idle(n);
      chk("bz_taken_cycles", n, 4);
      chk("bz_taken_upc", bus.upc, 15);
      bus.zero = 1'b0;
      exp_q.push_back(8'h05); exp_q.push_back(8'h33);
      start_op(OP_JBEG);
      wait_idle(n);
      chk("bz_fall_cycles", n, 4);
      chk("bz_fall_upc", bus.upc, 49);
      chk("bz_ucount", ucount, 5);
      // stall during EXEC of a SEQ word
      mem[0] = 16'h0021; mem[1] = 16'h4022;
      exp_q.push_back(8'h21); exp_q.push_back(8'h22);
      bus.ctrl_stall = 1'b1;
      start_op(OP_RIGHT);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", bus.ctrl_valid, 1);
         chk("stall_ctrl", bus.ctrl, 8'h21);
         chk("stall_upc", bus.upc, 0);
         chk("stall_ucount", ucount, 5);
         step();
      end
      bus.ctrl_stall = 1'b0;
      chk("stall_release_upc", bus.upc, 0);
      wait_idle(n);
      chk("stall_end_upc", bus.upc, 1);
      chk("stall_ucount_after", ucount, 7);
      // JMP to the last word holding a SEQ word overflows
      mem[24] = 16'hFF44; mem[63] = 16'h0000; mem[16] = 16'h4077;
      exp_q.push_back(8'h44); exp_q.push_back(8'h00);
      start_op(OP_DEC);
      wait_idle(n);
      chk("ovf_cycles", n, 4);
      chk("ovf_uerr", uerr, 1);
      chk("ovf_busy", busy, 0);
      chk("ovf_idle", bus.op_ready, 1);
      chk("ovf_upc", bus.upc, 63);
      exp_q.push_back(8'h77);
      start_op(OP_INC);
      wait_idle(n);
      chk("ovf_next_cycles", n, 2);
      chk("ovf_sticky", uerr, 1);
      chk("ovf_ucount", ucount, 10);
      // asynchronous reset in the middle of a three-word op
      mem[32] = 16'h0001; mem[33] = 16'h0002; mem[34] = 16'h4003;
      exp_q.push_back(8'h01);
      start_op(OP_OUT);
      repeat (3) step();
      chk("mid_valid", bus.ctrl_valid, 1);
      chk("mid_ctrl", bus.ctrl, 8'h02);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", bus.ctrl_valid, 0);
      chk("arst_upc", bus.upc, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ctrl", bus.ctrl, 0);
      chk("arst_ucount", ucount, 0);
      chk("arst_uerr", uerr, 0);
      chk("arst_ready", bus.op_ready, 0);
      chk("arst_queue", exp_q.size(), 0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("arst_release_ready", bus.op_ready, 1);
      // endless JMP loop on a narrow counter to reach saturation
      mem[40] = 16'hE85A;
      sbus.op_valid = 1'b1;
      sbus.op = OP_IN;
      step();
      sbus.op_valid = 1'b0;
      repeat (40) step();
      chk("sat_ucount", sucount, 4'hF);
      chk("sat_busy", sbusy, 1);
      chk("sat_uerr", suerr, 0);
      repeat (10) step();
      chk("sat_hold", sucount, 4'hF);
      chk("final_queue", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
